// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DCD/EXE/MEM/WB and drives all datapath selects and strobes.
// Optional feature: define MIPS_CTRL_ILLEGAL_TRAP_EN to trap illegal instructions (otherwise they retire as NOPs).
module mips_mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       im_ack,
  input  logic       dm_ack,
  output logic       im_rd,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic [1:0] npc_op,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic       b_sel,
  output logic       dm_rd,
  output logic       dm_wr,
  output logic       rf_wr,
  output logic [1:0] a3_sel,
  output logic [1:0] wd_sel,
  output logic [2:0] state,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_SLT   = 3'd4;
  localparam logic [2:0] ALU_PASSB = 3'd5;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  // Extender modes; ExtOp_WIDTH is 2.
  localparam logic [1:0] EXTOP_SIGNED = 2'd0;
  localparam logic [1:0] EXTOP_UNSIGN = 2'd1;
  localparam logic [1:0] EXTOP_HIGH16 = 2'd2;

  localparam logic [1:0] A3_RT = 2'd0;
  localparam logic [1:0] A3_RD = 2'd1;
  localparam logic [1:0] A3_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DCD   = 3'd1,
    S_EXE   = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_TRAP  = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic       is_r, is_ralu, is_jr, is_j, is_jal, is_beq, is_lw, is_sw, is_legal;
  logic [2:0] alu_x;
  logic       b_sel_x;

  always_comb begin
    is_r    = (op == OP_RTYPE);
    is_jr   = is_r && (funct == FN_JR);
    is_ralu = is_r && ((funct == FN_ADDU) || (funct == FN_SUBU) || (funct == FN_AND) ||
                       (funct == FN_OR)   || (funct == FN_SLT));
    is_j    = (op == OP_J);
    is_jal  = (op == OP_JAL);
    is_beq  = (op == OP_BEQ);
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_legal = is_ralu || is_jr || is_j || is_jal || is_beq || is_lw || is_sw ||
               (op == OP_ADDIU) || (op == OP_ORI) || (op == OP_LUI);
  end

  // ALU setup is a pure function of the instruction so it stays stable from EXE through WB.
  always_comb begin
    alu_x   = ALU_ADD;
    b_sel_x = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_SUBU: alu_x = ALU_SUB;
          FN_AND:  alu_x = ALU_AND;
          FN_OR:   alu_x = ALU_OR;
          FN_SLT:  alu_x = ALU_SLT;
          default: alu_x = ALU_ADD;
        endcase
      end
      OP_BEQ:   alu_x = ALU_SUB;
      OP_ORI:   begin alu_x = ALU_OR;    b_sel_x = 1'b1; end
      OP_LUI:   begin alu_x = ALU_PASSB; b_sel_x = 1'b1; end
      OP_ADDIU, OP_LW, OP_SW: begin alu_x = ALU_ADD; b_sel_x = 1'b1; end
      default:  alu_x = ALU_ADD;
    endcase
  end

  always_comb begin
    case (op)
      OP_ORI:  ext_op = EXTOP_UNSIGN;
      OP_LUI:  ext_op = EXTOP_HIGH16;
      default: ext_op = EXTOP_SIGNED;
    endcase
  end

  always_comb begin
    state_d = state_q;
    im_rd   = 1'b0;
    ir_wr   = 1'b0;
    pc_wr   = 1'b0;
    npc_op  = NPC_PC4;
    alu_op  = ALU_ADD;
    b_sel   = 1'b0;
    dm_rd   = 1'b0;
    dm_wr   = 1'b0;
    rf_wr   = 1'b0;
    a3_sel  = A3_RT;
    wd_sel  = WD_ALU;
    case (state_q)
      S_FETCH: begin
        im_rd = 1'b1;
        if (im_ack) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DCD;
        end
      end
      S_DCD: begin
        if (is_j || is_jal) begin
          pc_wr   = 1'b1;
          npc_op  = NPC_J;
          state_d = S_FETCH;
          if (is_jal) begin
            rf_wr  = 1'b1;
            a3_sel = A3_RA;
            wd_sel = WD_PC;
          end
        end else if (is_jr) begin
          pc_wr   = 1'b1;
          npc_op  = NPC_JR;
          state_d = S_FETCH;
        end else if (is_legal) begin
          state_d = S_EXE;
        end else begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXE: begin
        alu_op = alu_x;
        b_sel  = b_sel_x;
        if (is_beq) begin
          pc_wr   = zero;
          npc_op  = NPC_BR;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_op = alu_x;
        b_sel  = b_sel_x;
        dm_rd  = is_lw;
        dm_wr  = is_sw;
        if (dm_ack) state_d = is_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        alu_op  = alu_x;
        b_sel   = b_sel_x;
        rf_wr   = 1'b1;
        a3_sel  = is_r ? A3_RD : A3_RT;
        wd_sel  = is_lw ? WD_DM : WD_ALU;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    // Reset abandons whatever is in flight without touching memory, PC or registers.
    if (rst) begin
      state_d = S_FETCH;
      im_rd   = 1'b0;
      ir_wr   = 1'b0;
      pc_wr   = 1'b0;
      rf_wr   = 1'b0;
      dm_rd   = 1'b0;
      dm_wr   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  assign state = state_q;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if ((state_q == S_DCD) && !is_legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: each instruction is expanded into its expected per-cycle output trace, then replayed and compared.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, im_ack = 1'b0, dm_ack = 1'b0;
  logic       im_rd, ir_wr, pc_wr, b_sel, dm_rd, dm_wr, rf_wr, illegal;
  logic [1:0] npc_op, ext_op, a3_sel, wd_sel;
  logic [2:0] alu_op, state;

  always #5 clk = ~clk;

  mips_mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .im_ack(im_ack), .dm_ack(dm_ack), .im_rd(im_rd), .ir_wr(ir_wr),
    .pc_wr(pc_wr), .npc_op(npc_op), .ext_op(ext_op), .alu_op(alu_op),
    .b_sel(b_sel), .dm_rd(dm_rd), .dm_wr(dm_wr), .rf_wr(rf_wr),
    .a3_sel(a3_sel), .wd_sel(wd_sel), .state(state), .illegal(illegal)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       im_rd, ir_wr, pc_wr;
    logic [1:0] npc, ext;
    logic [2:0] alu;
    logic       b_sel, dm_rd, dm_wr, rf_wr;
    logic [1:0] a3, wd;
    logic       ill;
  } outv_t;

  typedef struct {
    logic       rst;
    logic [5:0] op, funct;
    logic       im_ack, dm_ack, zero;
    outv_t      o;
  } cyc_t;

  localparam int K_RALU = 0, K_JR = 1, K_J = 2, K_JAL = 3, K_BEQ = 4,
                 K_IALU = 5, K_LW = 6, K_SW = 7, K_ILL = 8;

  cyc_t       tr[$];
  cyc_t       cur_e;
  logic       exp_vld = 1'b0;
  logic [5:0] cur_op, cur_funct;
  logic       m_ill = 1'b0;
  int         checks = 0, errors = 0, cyc = 0;
  outv_t      dut_o;

  assign dut_o = {state, im_rd, ir_wr, pc_wr, npc_op, ext_op, alu_op, b_sel,
                  dm_rd, dm_wr, rf_wr, a3_sel, wd_sel, illegal};

  function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b000000: begin
        if (f == 6'b001000) return K_JR;
        if (f == 6'b100001 || f == 6'b100011 || f == 6'b100100 ||
            f == 6'b100101 || f == 6'b101010) return K_RALU;
        return K_ILL;
      end
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      6'b000100: return K_BEQ;
      6'b001001, 6'b001101, 6'b001111: return K_IALU;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic logic [1:0] ext_of(input logic [5:0] o);
    if (o == 6'b001101) return 2'd1;
    if (o == 6'b001111) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b000100: return 3'd1;
      6'b001101: return 3'd3;
      6'b001111: return 3'd5;
      6'b000000: case (f)
                   6'b100011: return 3'd1;
                   6'b100100: return 3'd2;
                   6'b100101: return 3'd3;
                   6'b101010: return 3'd4;
                   default:   return 3'd0;
                 endcase
      default:   return 3'd0;
    endcase
  endfunction

  function automatic logic bsel_of(input logic [5:0] o);
    return (o == 6'b001001) || (o == 6'b001101) || (o == 6'b001111) ||
           (o == 6'b100011) || (o == 6'b101011);
  endfunction

  // A cycle with nothing asserted; acks and zero are random noise the DUT must ignore.
  function automatic cyc_t blank();
    cyc_t c;
    c.rst    = 1'b0;
    c.op     = cur_op;
    c.funct  = cur_funct;
    c.im_ack = 1'($urandom % 2);
    c.dm_ack = 1'($urandom % 2);
    c.zero   = 1'($urandom % 2);
    c.o      = '0;
    c.o.ext  = ext_of(cur_op);
    c.o.ill  = m_ill;
    return c;
  endfunction

  function automatic cyc_t alu_cyc(input logic [2:0] st);
    cyc_t c;
    c          = blank();
    c.o.st     = st;
    c.o.alu    = alu_of(cur_op, cur_funct);
    c.o.b_sel  = bsel_of(cur_op);
    return c;
  endfunction

  task automatic push_reset();
    cyc_t c;
    c     = blank();
    c.rst = 1'b1;
    tr.push_back(c);
    m_ill = 1'b0;
  endtask

  task automatic build(input logic [5:0] o, input logic [5:0] f, input int imw,
                       input int dmw, input logic zv);
    cyc_t c;
    int   k;
    cur_op = o; cur_funct = f;
    k = kind_of(o, f);
    for (int i = 0; i < imw; i++) begin
      c = blank(); c.im_ack = 1'b0; c.o.im_rd = 1'b1; tr.push_back(c);
    end
    c = blank(); c.im_ack = 1'b1;
    c.o.im_rd = 1'b1; c.o.ir_wr = 1'b1; c.o.pc_wr = 1'b1;
    tr.push_back(c);
    c = blank(); c.o.st = 3'd1;
    if (k == K_J || k == K_JAL) begin c.o.pc_wr = 1'b1; c.o.npc = 2'd2; end
    if (k == K_JAL) begin c.o.rf_wr = 1'b1; c.o.a3 = 2'd2; c.o.wd = 2'd2; end
    if (k == K_JR) begin c.o.pc_wr = 1'b1; c.o.npc = 2'd3; end
    tr.push_back(c);
    if (k == K_J || k == K_JAL || k == K_JR) return;
    if (k == K_ILL) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      m_ill = 1'b1;
      for (int i = 0; i < 3; i++) begin
        c = blank(); c.o.st = 3'd5; tr.push_back(c);
      end
      push_reset();
`endif
      return;
    end
    c = alu_cyc(3'd2);
    if (k == K_BEQ) begin
      c.zero = zv; c.o.pc_wr = zv; c.o.npc = 2'd1;
      tr.push_back(c);
      return;
    end
    tr.push_back(c);
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= dmw; i++) begin
        c = alu_cyc(3'd3);
        c.dm_ack  = (i == dmw);
        c.o.dm_rd = (k == K_LW);
        c.o.dm_wr = (k == K_SW);
        tr.push_back(c);
      end
      if (k == K_SW) return;
    end
    c = alu_cyc(3'd4);
    c.o.rf_wr = 1'b1;
    c.o.a3    = (k == K_RALU) ? 2'd1 : 2'd0;
    c.o.wd    = (k == K_LW) ? 2'd1 : 2'd0;
    tr.push_back(c);
  endtask

  task automatic pin(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: model gave %0d, hand value %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_vld) begin
      checks++;
      if (cur_e.rst) begin
        if ({im_rd, ir_wr, pc_wr, rf_wr, dm_rd, dm_wr} !== 6'b0) begin
          errors++;
          $display("FAIL reset_strobes cycle %0d: got %b required 000000", cyc,
                   {im_rd, ir_wr, pc_wr, rf_wr, dm_rd, dm_wr});
        end
      end else if (dut_o !== cur_e.o) begin
        errors++;
        $display("FAIL outputs cycle %0d op %b funct %b: got %b required %b (state got %0d req %0d)",
                 cyc, cur_e.op, cur_e.funct, dut_o, cur_e.o, state, cur_e.o.st);
      end
    end
  end

  logic [5:0] t_op[14]  = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                            6'b000010, 6'b000011, 6'b000100, 6'b001001, 6'b001101, 6'b001111,
                            6'b100011, 6'b101011};
  logic [5:0] t_fn[14]  = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010, 6'b001000,
                            6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    int n0, cnt;
    cyc_t e;
    logic [5:0] ro, rf;
    int r;

    push_reset();
    push_reset();

    n0 = tr.size(); build(6'b000000, 6'b100001, 0, 0, 1'b0);
    pin("addu_len", tr.size() - n0, 4);
    pin("addu_wb_state", int'(tr[n0+3].o.st), 4);
    pin("addu_wb_a3", int'(tr[n0+3].o.a3), 1);
    cnt = 0;
    for (int i = n0; i < tr.size(); i++) cnt += int'(tr[i].o.pc_wr);
    pin("addu_pcwr_count", cnt, 1);

    n0 = tr.size(); build(6'b001111, 6'h00, 1, 0, 1'b0);
    pin("lui_exe_alu", int'(tr[n0+3].o.alu), 5);
    pin("lui_ext", int'(tr[n0+3].o.ext), 2);
    n0 = tr.size(); build(6'b001101, 6'h00, 0, 0, 1'b0);
    pin("ori_ext", int'(tr[n0].o.ext), 1);
    build(6'b001001, 6'h00, 0, 0, 1'b0);

    n0 = tr.size(); build(6'b100011, 6'h00, 0, 3, 1'b0);
    pin("lw_len", tr.size() - n0, 8);
    cnt = 0;
    for (int i = n0; i < tr.size(); i++) cnt += int'(tr[i].o.dm_rd);
    pin("lw_dmrd_cycles", cnt, 4);
    pin("lw_wb_wd", int'(tr[n0+7].o.wd), 1);

    n0 = tr.size(); build(6'b000100, 6'h00, 0, 0, 1'b1);
    pin("beq_len", tr.size() - n0, 3);
    pin("beq_taken_pcwr", int'(tr[n0+2].o.pc_wr), 1);
    n0 = tr.size(); build(6'b000100, 6'h00, 0, 0, 1'b0);
    pin("beq_nottaken_pcwr", int'(tr[n0+2].o.pc_wr), 0);

    n0 = tr.size(); build(6'b000011, 6'h00, 0, 0, 1'b0);
    pin("jal_len", tr.size() - n0, 2);
    pin("jal_dcd_npc", int'(tr[n0+1].o.npc), 2);
    pin("jal_dcd_a3", int'(tr[n0+1].o.a3), 2);

    build(6'b101011, 6'h00, 2, 2, 1'b0);
    build(6'b111111, 6'h00, 0, 0, 1'b0);
    build(6'b000000, 6'b001000, 0, 0, 1'b0);

    // lw stalled in MEM, abandoned by reset
    n0 = tr.size(); build(6'b100011, 6'h00, 0, 5, 1'b0);
    while (tr.size() > n0 + 5) void'(tr.pop_back());
    push_reset();
    build(6'b000000, 6'b101010, 0, 0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom % 17;
      if (r < 14) begin
        ro = t_op[r]; rf = t_fn[r];
      end else if (r == 14) begin
        ro = 6'($urandom); rf = 6'($urandom);
      end else begin
        ro = 6'b000000; rf = 6'($urandom);
      end
      if (r < 14 && ro != 6'b000000) rf = 6'($urandom);
      build(ro, rf, ($urandom % 4 == 0) ? int'($urandom % 3) : 0,
            ($urandom % 3 == 0) ? int'($urandom % 4) : 0, 1'($urandom % 2));
      if ($urandom % 40 == 0) push_reset();
    end

    while (tr.size() > 0) begin
      e = tr.pop_front();
      @(posedge clk);
      #1;
      rst = e.rst; op = e.op; funct = e.funct;
      im_ack = e.im_ack; dm_ack = e.dm_ack; zero = e.zero;
      cur_e = e;
      exp_vld = 1'b1;
      cyc++;
    end
    @(posedge clk);
    #1 exp_vld = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
